// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit.
//   PC_SEQ/PC_BR/PC_JALR/PC_TRAP : next-PC select encoding on pcsrc
//   DEF_RESET_VECTOR / DEF_TRAP_VECTOR : default vector parameters
package pc_pkg;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;
  localparam logic [1:0] PC_TRAP = 2'b11;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the control/ALU target logic and the PC unit.
//   master : control side, drives stall/pcsrc/targets, observes PC state
//   slave  : pc_sequencer, consumes the select and produces PC state
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [1:0]      pcsrc;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect_pending;
  logic            misaligned_exc;
  logic [XLEN-1:0] epc;

  modport master (
    output stall, pcsrc, pc_target, jalr_target,
    input  pc, pc_plus4, redirect_pending, misaligned_exc, epc
  );

  modport slave (
    input  stall, pcsrc, pc_target, jalr_target,
    output pc, pc_plus4, redirect_pending, misaligned_exc, epc
  );
endinterface

// File: rtl/pc_sequencer_target_sel.sv
// Combinational next-PC source select with JALR bit-0 clear and
// alignment check on BR/JALR targets.
//   pcsrc_i, pc_plus4_i, pc_target_i, jalr_target_i : select and sources
//   target_o     : resolved target (trap vector when misaligned)
//   misaligned_o : BR/JALR target has nonzero low ALIGN_BITS bits
//   raw_o        : selected target before the misalignment substitution
module pc_target_sel
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR),
  parameter int              ALIGN_BITS  = 2
) (
  input  logic [1:0]      pcsrc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] raw_o
);
  logic chk_align;

  always_comb begin
    raw_o     = pc_plus4_i;
    chk_align = 1'b0;
    case (pcsrc_i)
      PC_SEQ:  raw_o = pc_plus4_i;
      PC_BR: begin
        raw_o     = pc_target_i;
        chk_align = 1'b1;
      end
      PC_JALR: begin
        raw_o     = jalr_target_i & ~XLEN'(1);
        chk_align = 1'b1;
      end
      default: raw_o = TRAP_VECTOR;
    endcase
    misaligned_o = chk_align && (raw_o[ALIGN_BITS-1:0] != '0);
    target_o     = misaligned_o ? TRAP_VECTOR : raw_o;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, deferred-redirect holding during
// stalls, misaligned-target trap with EPC capture.
//   clk, rst_n : core clock, async active-low reset
//   bus        : slave side of pc_sequencer_if (select/targets in, PC state out)
//
// state | meaning
// IDLE  | no redirect held
// HELD  | redirect captured during a stall, applied on stall release
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              ALIGN_BITS   = 2
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_trap_q, pend_trap_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            exc_q, exc_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] raw;
  logic            misal;
  logic            live_redir;
  logic            live_trap;

  assign pc_plus4 = pc_q + XLEN'(4);

  pc_target_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .ALIGN_BITS  (ALIGN_BITS)
  ) u_target_sel (
    .pcsrc_i       (bus.pcsrc),
    .pc_plus4_i    (pc_plus4),
    .pc_target_i   (bus.pc_target),
    .jalr_target_i (bus.jalr_target),
    .target_o      (target),
    .misaligned_o  (misal),
    .raw_o         (raw)
  );

  assign live_redir = (bus.pcsrc != PC_SEQ);
  assign live_trap  = misal || (bus.pcsrc == PC_TRAP);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_tgt_d  = pend_tgt_q;
    pend_trap_d = pend_trap_q;
    // misalignment is reported when presented, stalled or not
    exc_d       = misal;
    epc_d       = misal ? raw : epc_q;

    if (!bus.stall) begin
      state_d     = ST_IDLE;
      pend_trap_d = 1'b0;
      // a held trap beats any live redirect; a held non-trap only beats SEQ
      if ((state_q == ST_HELD) && (!live_redir || pend_trap_q)) begin
        pc_d = pend_tgt_q;
      end else begin
        pc_d = target;
      end
    end else if (live_redir) begin
      state_d = ST_HELD;
      if ((state_q == ST_IDLE) || !pend_trap_q || live_trap) begin
        pend_tgt_d  = target;
        pend_trap_d = live_trap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VECTOR;
      pend_tgt_q  <= '0;
      pend_trap_q <= 1'b0;
      epc_q       <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_trap_q <= pend_trap_d;
      epc_q       <= epc_d;
      exc_q       <= exc_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_plus4         = pc_plus4;
  assign bus.redirect_pending = (state_q == ST_HELD);
  assign bus.misaligned_exc   = exc_q;
  assign bus.epc              = epc_q;
endmodule
